// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, fetches over imem req/ack and hands words to the decoder,
// redirecting on resolved branches and discarding fetches made stale by a redirect.
module fetch_sequencer #(
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [DATA_WIDTH-1:0] PC_STEP    = DATA_WIDTH'(1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_run,
    output logic                  o_imem_req,
    output logic [DATA_WIDTH-1:0] o_imem_addr,
    input  logic                  i_imem_ack,
    input  logic [DATA_WIDTH-1:0] i_imem_data,
    output logic                  o_instr_valid,
    output logic [DATA_WIDTH-1:0] o_instr,
    input  logic                  i_instr_ready,
    output logic [DATA_WIDTH-1:0] o_program_count,
    input  logic                  i_branch_valid,
    input  logic [DATA_WIDTH-1:0] i_branch_addr,
    output logic                  o_busy
);
    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, FLUSH} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic                  req_q, req_d;
    logic                  valid_q, valid_d;
    logic                  busy_q;
    logic [DATA_WIDTH-1:0] tgt_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= '0;
            instr_q <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            busy_q  <= state_d != IDLE;
        end
    end

    // A branch arriving this cycle wins over both the current and the incremented PC.
    assign tgt_pc = i_branch_valid ? i_branch_addr : pc_q;

    always_comb begin
        state_d = state_q;
        pc_d    = tgt_pc;
        addr_d  = addr_q;
        instr_d = instr_q;
        req_d   = req_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (i_run) begin
                    state_d = FETCH;
                    req_d   = 1'b1;
                    addr_d  = tgt_pc;
                end
            end
            FETCH: begin
                if (i_imem_ack) begin
                    req_d   = 1'b0;
                    state_d = i_branch_valid ? IDLE : ISSUE;
                    if (!i_branch_valid) begin
                        valid_d = 1'b1;
                        instr_d = i_imem_data;
                        pc_d    = pc_q + PC_STEP;
                    end
                end else if (i_branch_valid) begin
                    state_d = FLUSH;
                end
            end
            ISSUE: begin
                if (i_instr_ready || i_branch_valid) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                if (i_imem_ack) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_imem_req      = req_q;
    assign o_imem_addr     = addr_q;
    assign o_instr_valid   = valid_q;
    assign o_instr         = instr_q;
    assign o_program_count = pc_q;
    assign o_busy          = busy_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scenarios against a transaction-level model of the sequencer,
// checked on every falling edge plus hand-computed literal expectations.
module tb_fetch_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_run = 1'b0;
    logic       o_imem_req;
    logic [7:0] o_imem_addr;
    logic       i_imem_ack = 1'b0;
    logic [7:0] i_imem_data = 8'h00;
    logic       o_instr_valid;
    logic [7:0] o_instr;
    logic       i_instr_ready = 1'b0;
    logic [7:0] o_program_count;
    logic       i_branch_valid = 1'b0;
    logic [7:0] i_branch_addr = 8'h00;
    logic       o_busy;

    int n_vec = 0;
    int n_bad = 0;

    fetch_sequencer #(.DATA_WIDTH(8), .RESET_PC(8'h10), .PC_STEP(8'h01)) dut (
        .clk(clk), .rst_n(rst_n), .i_run(i_run),
        .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
        .i_imem_ack(i_imem_ack), .i_imem_data(i_imem_data),
        .o_instr_valid(o_instr_valid), .o_instr(o_instr), .i_instr_ready(i_instr_ready),
        .o_program_count(o_program_count),
        .i_branch_valid(i_branch_valid), .i_branch_addr(i_branch_addr),
        .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    // Model: an outstanding request (possibly stale), or a held instruction, or nothing.
    logic [7:0] m_pc = 8'h10;
    logic [7:0] m_addr = 8'h00;
    logic [7:0] m_instr = 8'h00;
    logic       m_req = 1'b0;
    logic       m_valid = 1'b0;
    logic       m_stale = 1'b0;
    logic [7:0] iss_exp[$];
    logic [7:0] iss_act[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = 8'h10; m_addr = 8'h00; m_instr = 8'h00;
            m_req = 1'b0; m_valid = 1'b0; m_stale = 1'b0;
        end else begin
            if (m_req) begin
                if (i_imem_ack) begin
                    m_req = 1'b0;
                    if (!m_stale && !i_branch_valid) begin
                        m_valid = 1'b1;
                        m_instr = i_imem_data;
                        m_pc = m_pc + 8'd1;
                    end
                    m_stale = 1'b0;
                end else if (i_branch_valid) m_stale = 1'b1;
            end else if (m_valid) begin
                if (i_instr_ready) begin
                    m_valid = 1'b0;
                    iss_exp.push_back(m_instr);
                end else if (i_branch_valid) m_valid = 1'b0;
            end else if (i_run) begin
                m_req = 1'b1;
                m_addr = i_branch_valid ? i_branch_addr : m_pc;
            end
            if (i_branch_valid) m_pc = i_branch_addr;
        end
    end

    always @(posedge clk)
        if (rst_n && o_instr_valid && i_instr_ready) iss_act.push_back(o_instr);

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h want %02h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b want %0b", nm, act, exp);
        end
    endtask

    task automatic chkn(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk1("req", o_imem_req, m_req);
        chk8("addr", o_imem_addr, m_addr);
        chk1("valid", o_instr_valid, m_valid);
        chk8("instr", o_instr, m_instr);
        chk8("pc", o_program_count, m_pc);
        chk1("busy", o_busy, m_req || m_valid);
        chkn("issued", iss_act.size(), iss_exp.size());
        if (iss_act.size() == iss_exp.size() && iss_act.size() > 0)
            chk8("issued_word", iss_act[$], iss_exp[$]);
    endtask

    task automatic req_wait(output logic [7:0] a);
        int i;
        for (i = 0; i < 20 && !o_imem_req; i++) tick();
        if (!o_imem_req) begin
            n_vec++;
            n_bad++;
            $display("FAIL req_timeout: got req=0 want req=1 within 20 cycles");
        end
        a = o_imem_addr;
    endtask

    task automatic ack_pulse();
        i_imem_ack = 1'b1;
        i_imem_data = o_imem_addr ^ 8'h5A;
        tick();
        i_imem_ack = 1'b0;
    endtask

    task automatic branch(input logic [7:0] t);
        i_branch_valid = 1'b1;
        i_branch_addr = t;
    endtask

    logic [7:0] a;

    initial begin
        tick(); tick();
        chk8("rst_pc", o_program_count, 8'h10);
        chk1("rst_busy", o_busy, 1'b0);
        rst_n = 1'b1;
        tick();
        // 1: sequential fetches, then PC wrap
        i_instr_ready = 1'b1; i_run = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_wait(a);
            chk8("t1_addr", a, 8'h10 + 8'(k));
            tick();
            ack_pulse();
        end
        i_run = 1'b0;
        tick(); tick();
        chk8("t1_pc", o_program_count, 8'h13);
        chkn("t1_count", iss_act.size(), 3);
        chk8("t1_first", iss_act[0], 8'h4A);
        chk8("t1_last", iss_act[2], 8'h48);
        branch(8'hFF); tick(); i_branch_valid = 1'b0;
        chk8("t1_pc_ff", o_program_count, 8'hFF);
        i_run = 1'b1;
        req_wait(a);
        chk8("t1_addr_ff", a, 8'hFF);
        ack_pulse(); i_run = 1'b0;
        tick(); tick();
        chk8("t1_wrap", o_program_count, 8'h00);
        chk8("t1_wrap_word", iss_act[$], 8'hA5);
        // 2: decoder stalls in ISSUE
        i_instr_ready = 1'b0; i_run = 1'b1;
        req_wait(a);
        chk8("t2_addr", a, 8'h00);
        ack_pulse();
        repeat (5) tick();
        chk1("t2_valid", o_instr_valid, 1'b1);
        chk8("t2_instr", o_instr, 8'h5A);
        chk1("t2_noreq", o_imem_req, 1'b0);
        chk8("t2_pc", o_program_count, 8'h01);
        i_instr_ready = 1'b1; i_run = 1'b0;
        tick(); tick();
        chk1("t2_accepted", o_instr_valid, 1'b0);
        chkn("t2_count", iss_act.size(), 5);
        // 3: branch mid-fetch, stale ack three cycles later
        i_instr_ready = 1'b0; i_run = 1'b1;
        req_wait(a);
        chk8("t3_addr", a, 8'h01);
        branch(8'h40); tick(); i_branch_valid = 1'b0;
        tick(); tick();
        ack_pulse();
        chk1("t3_stale_valid", o_instr_valid, 1'b0);
        chk8("t3_pc", o_program_count, 8'h40);
        req_wait(a);
        chk8("t3_redirect", a, 8'h40);
        i_instr_ready = 1'b1;
        ack_pulse(); i_run = 1'b0;
        tick(); tick();
        chk8("t3_pc_after", o_program_count, 8'h41);
        chk8("t3_word", iss_act[$], 8'h1A);
        // 4: branch with ack, then branch in ISSUE without ready
        i_instr_ready = 1'b0; i_run = 1'b1;
        req_wait(a);
        chk8("t4_addr", a, 8'h41);
        branch(8'h80); ack_pulse(); i_branch_valid = 1'b0;
        chk1("t4_drop1", o_instr_valid, 1'b0);
        req_wait(a);
        chk8("t4_addr80", a, 8'h80);
        ack_pulse();
        chk1("t4_held", o_instr_valid, 1'b1);
        branch(8'h90); tick(); i_branch_valid = 1'b0;
        chk1("t4_drop2", o_instr_valid, 1'b0);
        req_wait(a);
        chk8("t4_addr90", a, 8'h90);
        chkn("t4_count", iss_act.size(), 6);
        i_instr_ready = 1'b1;
        ack_pulse(); i_run = 1'b0;
        tick(); tick();
        chk8("t4_word", iss_act[$], 8'hCA);
        // 5: branch in the same cycle as the decoder accepts
        i_run = 1'b1;
        req_wait(a);
        chk8("t5_addr", a, 8'h91);
        ack_pulse();
        branch(8'h20); tick(); i_branch_valid = 1'b0;
        chkn("t5_count", iss_act.size(), 8);
        chk8("t5_word", iss_act[$], 8'hCB);
        req_wait(a);
        chk8("t5_addr20", a, 8'h20);
        i_run = 1'b0;
        ack_pulse(); tick(); tick();
        chkn("t5_once", iss_act.size(), 9);
        chk8("t5_pc", o_program_count, 8'h21);
        // 6: stray ack, run drop mid-fetch, reset during ISSUE
        i_imem_ack = 1'b1; i_imem_data = 8'hFF; tick(); i_imem_ack = 1'b0;
        chk1("t6_stray_busy", o_busy, 1'b0);
        chk8("t6_stray_pc", o_program_count, 8'h21);
        i_run = 1'b1;
        req_wait(a);
        chk8("t6_addr", a, 8'h21);
        i_run = 1'b0;
        tick();
        ack_pulse();
        repeat (4) tick();
        chk1("t6_parked_busy", o_busy, 1'b0);
        chk1("t6_parked_req", o_imem_req, 1'b0);
        chk8("t6_pc", o_program_count, 8'h22);
        chkn("t6_count", iss_act.size(), 10);
        i_instr_ready = 1'b0; i_run = 1'b1;
        req_wait(a);
        chk8("t6_addr2", a, 8'h22);
        ack_pulse(); i_run = 1'b0;
        chk1("t6_issue", o_instr_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("t6_rst_req", o_imem_req, 1'b0);
        chk8("t6_rst_addr", o_imem_addr, 8'h00);
        chk1("t6_rst_valid", o_instr_valid, 1'b0);
        chk8("t6_rst_instr", o_instr, 8'h00);
        chk1("t6_rst_busy", o_busy, 1'b0);
        chk8("t6_rst_pc", o_program_count, 8'h10);
        tick();
        rst_n = 1'b1;
        tick(); tick();
        chk8("t6_post_pc", o_program_count, 8'h10);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
